score_disp_mux: RTL

Parametrised successor to the fixed 4-digit score display driver. It captures a binary score and converts it to BCD with a sequential double-dabble engine. It then scans N common-anode 7-segment digits at a divided refresh rate, with leading-zero blanking, overflow dashes, per-digit decimal points and whole-display blink. It sits between game score logic and the board's an/seg/dp pins.

---
 rtl/score_disp_mux.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/score_disp_mux.sv
// Binary score to N-digit multiplexed 7-segment display driver.
// A sequential double-dabble converter feeds a scanned, blanked, blinkable common-anode display.
module score_disp_mux #(
    parameter int N_DIGITS    = 4,
    parameter int VAL_W       = 14,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [VAL_W-1:0]    value,
    input  logic                load,
    input  logic                blank_lz,
    input  logic                blink_en,
    input  logic [N_DIGITS-1:0] dp,
    output logic                busy,
    output logic                overflow,
    output logic [N_DIGITS-1:0] an,
    output logic [6:0]          seg,
    output logic                dp_out
);

    localparam int BCD_W = 4 * N_DIGITS;
    localparam int CNT_W = $clog2(VAL_W + 1);
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } conv_state_e;

    conv_state_e         state_q, state_d;
    logic [VAL_W-1:0]    sr_bin_q, sr_bin_d;
    logic [BCD_W-1:0]    sr_bcd_q, sr_bcd_d;
    logic                carry_q, carry_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                overflow_q, overflow_d;
    logic [BCD_W-1:0]    disp_q, disp_d;
    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BLK_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic                phase_q, phase_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_out_q, dp_out_d;

    logic                tick;
    logic [BCD_W-1:0]    bcd_adj;
    logic [N_DIGITS-1:0] lz_mask;
    logic                zero_run;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_lz;
    logic [N_DIGITS-1:0] an_sel;

    function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] nib);
        case (nib)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_OFF;
        endcase
    endfunction

    // Converter. The bit leaving the top nibble after adjustment is a decimal carry out
    // of the displayable range; once set it stays set, so it flags value > 10^N_DIGITS-1.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        sr_bin_d   = sr_bin_q;
        sr_bcd_d   = sr_bcd_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        overflow_d = overflow_q;
        disp_d     = disp_q;
        bcd_adj    = dabble_adj(sr_bcd_q);

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    sr_bin_d = value;
                    sr_bcd_d = '0;
                    carry_d  = 1'b0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sr_bcd_d = {bcd_adj[BCD_W-2:0], sr_bin_q[VAL_W-1]};
                sr_bin_d = sr_bin_q << 1;
                carry_d  = carry_q | bcd_adj[BCD_W-1];
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(VAL_W - 1)) state_d = S_DONE;
            end
            S_DONE: begin
                disp_d     = sr_bcd_q;
                overflow_d = carry_q;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Scan timing: prescaler tick advances the digit index and the blink phase counter.
    always_comb begin
        tick        = (presc_q == PRE_W'(REFRESH_DIV - 1));
        presc_d     = tick ? '0 : presc_q + 1'b1;
        idx_d       = idx_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (tick) begin
            idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // Digit selection, leading-zero mask and the registered pin values.
    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run & (disp_q[4*i +: 4] == 4'd0);
            lz_mask[i] = zero_run;
        end
        lz_mask[0] = 1'b0;

        cur_nib = 4'd0;
        cur_dp  = 1'b0;
        cur_lz  = 1'b0;
        an_sel  = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = disp_q[4*i +: 4];
                cur_dp    = dp[i];
                cur_lz    = lz_mask[i];
                an_sel[i] = 1'b0;
            end
        end

        an_d     = an_q;
        seg_d    = seg_q;
        dp_out_d = dp_out_q;
        if (tick) begin
            an_d     = (!blink_en || phase_q) ? an_sel : '1;
            dp_out_d = ~cur_dp;
            if (overflow_q)              seg_d = SEG_DASH;
            else if (blank_lz && cur_lz) seg_d = SEG_OFF;
            else                         seg_d = seg_of(cur_nib);
        end
    end

    // NOTE: non-blocking assignments only here, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sr_bin_q    <= '0;
            sr_bcd_q    <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
            // NOTE: the display register is a plain register, so it is cleared by reset.
            disp_q      <= '0;
            presc_q     <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            an_q        <= '1;
            seg_q       <= SEG_OFF;
            dp_out_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            sr_bin_q    <= sr_bin_d;
            sr_bcd_q    <= sr_bcd_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
            disp_q      <= disp_d;
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_out_q    <= dp_out_d;
        end
    end

    assign busy     = busy_q;
    assign overflow = overflow_q;
    assign an       = an_q;
    assign seg      = seg_q;
    assign dp_out   = dp_out_q;

endmodule
